score_keeper: RTL and testbench
===============================

# score_keeper

Game-statistics accumulator for the DE2 falling-block game. It sits directly upstream of the two-digit score display. It consumes line-clear events from the playfield/lock logic, tracks total lines and level, and computes points. It drives an 8-bit binary score held in 0..99 so the downstream two-digit decimal display never overflows.

## Interface
- `MAX_SCORE`, default 99: score saturation ceiling.
- `LINES_PER_LEVEL`, default 10: lines needed per level step.
- `MAX_LEVEL`, default 9: level ceiling.
- `clk`  in  1  system clock (50 MHz).
- `rst_n`  in  1  reset; one clock, reset asynchronous and active-low.
- `game_start`  in  1  one-cycle pulse; zero all statistics and enter RUN.
- `game_over`  in  1  one-cycle pulse; freeze statistics, enter OVER.
- `lock_valid`  in  1  one-cycle pulse; a piece has locked.
- `lock_lines`  in  3  lines cleared by that lock, 0..4. Values 5..7 are treated as 4.
- `score`  out  8  binary score, 0..MAX_SCORE, feeds the display.
- `level`  out  4  current level, 0..MAX_LEVEL.
- `lines_total`  out  8  cleared lines, saturating at 255.
- `score_tick`  out  1  one-cycle pulse in the cycle `score` changes value.
- `running`  out  1  high in RUN state.

## Operation
- FSM `IDLE`→`RUN` on `game_start`. `RUN`→`OVER` on `game_over`. `OVER`→`RUN` on `game_start`. `IDLE` ignores `game_over`.
- `lock_valid` is accepted only in `RUN`. It is ignored in `IDLE`/`OVER`.
- Base points by lines: 0→0, 1→1, 2→3, 3→5, 4→8.
- Points = base × (level+1), using the level *before* this event. Maximum 8×10=80, so 7 bits are enough.
- Stage 1 (on acceptance):
  - register the points;
  - `lines_total += lines`, saturating at 255;
  - `level = min(lines_total_new / LINES_PER_LEVEL, MAX_LEVEL)`.
- Stage 2:
  - `score = min(score + points, MAX_SCORE)`, computed in 8-bit;
  - `score + points` never exceeds 179, so no wrap occurs;
  - `score_tick` = 1 only if the new value differs from the old one.
- A lock with 0 lines is a valid event: it adds no points and does not pulse `score_tick`.
- `game_start` in any state:
  - zeroes `score`, `level`, `lines_total`;
  - kills an in-flight stage-1 result (no commit);
  - `score_tick` = 0 that cycle.
- `game_start` and `lock_valid` in the same cycle: `game_start` wins and the lock is dropped.
- `game_over` and `lock_valid` in the same cycle: the lock is dropped. An already in-flight stage-1 result still commits to `score`.

## Timing
- Reset values:
  - `score`=0, `level`=0, `lines_total`=0, `score_tick`=0, `running`=0;
  - state `IDLE`;
  - stage-1 valid=0.
- Latency:
  - `lines_total`/`level` update on the edge after the accepted `lock_valid` (1 cycle);
  - `score`/`score_tick` update on the following edge (2 cycles).
- Throughput is one event per cycle. Back-to-back locks are fully pipelined. The second lock uses the level produced by the first lock's stage 1.
- `running` is registered from the state and is high from the edge after `game_start`.
- Asserting `rst_n` low mid-pipeline clears everything immediately. No pending commit survives.

## Configuration
- `SCORE_COMBO_EN`:
  - When defined, a combo counter (3 bits, saturating at 7) increments on every accepted lock with lines > 0 and clears on a lock with 0 lines or on `game_start`.
  - Points become base × (level+1) + combo_before_increment, with a maximum of 87.
  - Undefined: there is no combo logic and points follow the plain formula.

## Structure
- `score_pkg` holds:
  - the `MAX_SCORE`, `MAX_LEVEL`, `LINES_PER_LEVEL` defaults;
  - the base-points table constant;
  - the state enum (`IDLE`, `RUN`, `OVER`).
- Sub-module `points_lut`: combinational lines+level(+combo) → points. It is instantiated in stage 1.

## Test plan
- Reset, `game_start`, then lock with lines=4 at level 0 → `lines_total`=4 after 1 cycle; `score`=8 with `score_tick` after 2 cycles.
- Locks totalling 10 lines, then lock with lines=2 → `level`=1 and points 3×2=6 added.
- Drive score to 95, then lock with lines=4 at level 2 (24 pts) → `score`=99. A further 1-line lock → `score` stays 99 and `score_tick`=0.
- Lock and `game_start` in the same cycle with a lock in flight → all outputs 0 next cycle, no commit afterwards.
- `game_over`, then a lock with lines=4 → no change. In-flight points issued in the `game_over` cycle still land.
- `SCORE_COMBO_EN`: three consecutive 1-line locks at level 0 → scores 1, 3, 6. Then a 0-line lock and a 1-line lock → score 7.

Source files
------------

// File: rtl/score_pkg.sv
// Shared constants, base-points table and state encoding for the score keeper.
package score_pkg;

    localparam int unsigned DEF_MAX_SCORE       = 99;
    localparam int unsigned DEF_LINES_PER_LEVEL = 10;
    localparam int unsigned DEF_MAX_LEVEL       = 9;

    // Base points per lines cleared, packed 4 bits per entry: index 0..4 -> 0,1,3,5,8.
    localparam logic [19:0] BASE_POINTS = {4'd8, 4'd5, 4'd3, 4'd1, 4'd0};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OVER
    } state_e;

    // Lock line counts above 4 are physically impossible; treat them as a tetris.
    function automatic logic [2:0] clamp_lines(input logic [2:0] lines);
        return (lines > 3'd4) ? 3'd4 : lines;
    endfunction

    function automatic logic [3:0] base_points(input logic [2:0] lines);
        logic [3:0] base;
        case (lines)
            3'd0:    base = BASE_POINTS[3:0];
            3'd1:    base = BASE_POINTS[7:4];
            3'd2:    base = BASE_POINTS[11:8];
            3'd3:    base = BASE_POINTS[15:12];
            default: base = BASE_POINTS[19:16];
        endcase
        return base;
    endfunction

endpackage

// File: rtl/points_lut.sv
// Combinational points calculator: base(lines) x (level + 1), plus the combo bonus
// when SCORE_COMBO_EN is defined. Expects lines already clamped to 0..4.
module points_lut
    import score_pkg::*;
(
    input  logic [2:0] lines,
    input  logic [3:0] level,
`ifdef SCORE_COMBO_EN
    input  logic [2:0] combo,
`endif
    output logic [6:0] points
);

    logic [6:0] base;
    logic [6:0] mult;
    logic [6:0] product;

    // Multiply in 7 bits; 8 x 10 (+7 combo) stays below 128.
    always_comb begin
        base    = {3'b000, base_points(lines)};
        mult    = {3'b000, level} + 7'd1;
        product = base * mult;
`ifdef SCORE_COMBO_EN
        // A zero-line lock earns nothing, not even the combo bonus.
        points  = (lines != 3'd0) ? product + {4'b0000, combo} : 7'd0;
`else
        points  = product;
`endif
    end

endmodule

// File: rtl/score_keeper.sv
// Game statistics accumulator: lines, level and saturating two-digit score.
// Two-stage pipeline: stage 1 registers points/lines/level, stage 2 commits score.
// Optional feature: define SCORE_COMBO_EN to add the consecutive-clear combo bonus.
module score_keeper
    import score_pkg::*;
#(
    parameter int unsigned MAX_SCORE       = DEF_MAX_SCORE,
    parameter int unsigned LINES_PER_LEVEL = DEF_LINES_PER_LEVEL,
    parameter int unsigned MAX_LEVEL       = DEF_MAX_LEVEL
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       game_start,
    input  logic       game_over,
    input  logic       lock_valid,
    input  logic [2:0] lock_lines,
    output logic [7:0] score,
    output logic [3:0] level,
    output logic [7:0] lines_total,
    output logic       score_tick,
    output logic       running
);

    localparam logic [7:0] MaxScoreL = 8'(MAX_SCORE);
    localparam logic [3:0] MaxLevelL = 4'(MAX_LEVEL);
    localparam logic [7:0] LplL      = 8'(LINES_PER_LEVEL);

    state_e     state_q, state_d;
    logic       running_q;
    logic       s1_valid_q;
    logic [6:0] s1_points_q;
    logic [7:0] lines_q;
    logic [3:0] level_q;
    logic [7:0] score_q;
    logic       tick_q;

    logic       accept;
    logic [2:0] lines_eff;
    logic [8:0] lines_sum;
    logic [7:0] lines_new;
    logic [7:0] level_quot;
    logic [3:0] level_new;
    logic [6:0] points;
    logic [7:0] score_sum;
    logic [7:0] score_new;

`ifdef SCORE_COMBO_EN
    logic [2:0] combo_q;
    logic [2:0] combo_d;
`endif

    // Next game state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (game_start) state_d = RUN;
            RUN:     if (game_start) state_d = RUN;
                     else if (game_over) state_d = OVER;
            OVER:    if (game_start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // State register; running is registered so it rises on the edge after game_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == RUN);
        end
    end

    // Stage-1 combinational: acceptance, saturating line total and level.
    always_comb begin
        // game_start and game_over both drop a coincident lock.
        accept     = lock_valid && (state_q == RUN) && !game_start && !game_over;
        lines_eff  = clamp_lines(lock_lines);
        lines_sum  = {1'b0, lines_q} + {6'b000000, lines_eff};
        lines_new  = lines_sum[8] ? 8'hff : lines_sum[7:0];
        level_quot = lines_new / LplL;
        level_new  = (level_quot > {4'b0000, MaxLevelL}) ? MaxLevelL : level_quot[3:0];
    end

`ifdef SCORE_COMBO_EN
    // Combo counts consecutive clearing locks, saturating at 7.
    always_comb begin
        combo_d = combo_q;
        if (accept) begin
            if (lines_eff == 3'd0) combo_d = 3'd0;
            else if (combo_q != 3'd7) combo_d = combo_q + 3'd1;
        end
    end
`endif

    points_lut u_points_lut (
        .lines  (lines_eff),
        .level  (level_q),
`ifdef SCORE_COMBO_EN
        .combo  (combo_q),
`endif
        .points (points)
    );

    // Stage-2 combinational: saturating score; sum is at most 99 + 87 so 8 bits suffice.
    always_comb begin
        score_sum = score_q + {1'b0, s1_points_q};
        score_new = (score_sum > MaxScoreL) ? MaxScoreL : score_sum;
    end

    // Statistics pipeline; game_start zeroes everything and kills the stage-1 result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_points_q <= 7'd0;
            lines_q     <= 8'd0;
            level_q     <= 4'd0;
            score_q     <= 8'd0;
            tick_q      <= 1'b0;
`ifdef SCORE_COMBO_EN
            combo_q     <= 3'd0;
`endif
        end else if (game_start) begin
            s1_valid_q  <= 1'b0;
            s1_points_q <= 7'd0;
            lines_q     <= 8'd0;
            level_q     <= 4'd0;
            score_q     <= 8'd0;
            tick_q      <= 1'b0;
`ifdef SCORE_COMBO_EN
            combo_q     <= 3'd0;
`endif
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_points_q <= points;
                lines_q     <= lines_new;
                level_q     <= level_new;
            end
`ifdef SCORE_COMBO_EN
            combo_q <= combo_d;
`endif
            // An in-flight result commits even after game_over.
            if (s1_valid_q) begin
                score_q <= score_new;
                tick_q  <= (score_new != score_q);
            end else begin
                tick_q  <= 1'b0;
            end
        end
    end

    assign score       = score_q;
    assign level       = level_q;
    assign lines_total = lines_q;
    assign score_tick  = tick_q;
    assign running     = running_q;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: reference model pushes expected stage-1 and
// stage-2 results into queues tagged with the cycle they are due.
module tb_score_keeper;

    logic       clk;
    logic       rst_n;
    logic       game_start;
    logic       game_over;
    logic       lock_valid;
    logic [2:0] lock_lines;
    logic [7:0] score;
    logic [3:0] level;
    logic [7:0] lines_total;
    logic       score_tick;
    logic       running;

    score_keeper dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .game_start  (game_start),
        .game_over   (game_over),
        .lock_valid  (lock_valid),
        .lock_lines  (lock_lines),
        .score       (score),
        .level       (level),
        .lines_total (lines_total),
        .score_tick  (score_tick),
        .running     (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] lines;
        logic [3:0] level;
    } s1_exp_t;

    typedef struct {
        int         due;
        logic [7:0] score;
        logic       tick;
    } s2_exp_t;

    s1_exp_t q1[$];
    s2_exp_t q2[$];

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    // Reference model state (values as of acceptance, not pipelined).
    int         m_state = 0;   // 0 idle, 1 run, 2 over
    int         m_lines = 0;
    int         m_level = 0;
    int         m_score = 0;
    int         m_combo = 0;
    logic [7:0] m_disp  = 8'd0;  // score currently visible on the output
    int         base_tb[5] = '{0, 1, 3, 5, 8};

    task automatic model_clear();
        m_lines = 0;
        m_level = 0;
        m_score = 0;
        m_combo = 0;
        m_disp  = 8'd0;
        q1.delete();
        q2.delete();
    endtask

    // Advance one clock, then compare whatever the scoreboard has due.
    task automatic cyc();
        s1_exp_t e1;
        s2_exp_t e2;
        @(posedge clk);
        #1;
        cycle++;
        checks++;
        if (running !== (m_state == 1)) begin
            failures++;
            $display("FAIL running cyc=%0d got=%0b want=%0b", cycle, running, (m_state == 1));
        end
        if (q1.size() > 0 && q1[0].due == cycle) begin
            e1 = q1.pop_front();
            checks++;
            if (lines_total !== e1.lines || level !== e1.level) begin
                failures++;
                $display("FAIL stage1 cyc=%0d got lines=%0d level=%0d want lines=%0d level=%0d",
                         cycle, lines_total, level, e1.lines, e1.level);
            end
        end
        checks++;
        if (q2.size() > 0 && q2[0].due == cycle) begin
            e2 = q2.pop_front();
            m_disp = e2.score;
            if (score !== e2.score || score_tick !== e2.tick) begin
                failures++;
                $display("FAIL stage2 cyc=%0d got score=%0d tick=%0b want score=%0d tick=%0b",
                         cycle, score, score_tick, e2.score, e2.tick);
            end
        end else if (score !== m_disp || score_tick !== 1'b0) begin
            failures++;
            $display("FAIL steady cyc=%0d got score=%0d tick=%0b want score=%0d tick=0",
                     cycle, score, score_tick, m_disp);
        end
    endtask

    // Drive one cycle of inputs, update the model, advance the clock.
    task automatic drive(input logic st, input logic ov, input logic lv, input logic [2:0] ll);
        int l;
        int pts;
        int nscore;
        game_start = st;
        game_over  = ov;
        lock_valid = lv;
        lock_lines = ll;
        if (st) begin
            model_clear();
            m_state = 1;
        end else begin
            if (lv && m_state == 1 && !ov) begin
                l   = (ll > 3'd4) ? 4 : int'(ll);
                pts = base_tb[l] * (m_level + 1);
`ifdef SCORE_COMBO_EN
                if (l > 0) begin
                    pts     = pts + m_combo;
                    m_combo = (m_combo < 7) ? m_combo + 1 : 7;
                end else begin
                    m_combo = 0;
                end
`endif
                m_lines = (m_lines + l > 255) ? 255 : m_lines + l;
                m_level = (m_lines / 10 > 9) ? 9 : m_lines / 10;
                q1.push_back('{due: cycle + 1, lines: 8'(m_lines), level: 4'(m_level)});
                nscore = (m_score + pts > 99) ? 99 : m_score + pts;
                q2.push_back('{due: cycle + 2, score: 8'(nscore), tick: (nscore != m_score)});
                m_score = nscore;
            end
            if (ov && m_state == 1) m_state = 2;
        end
        cyc();
        game_start = 1'b0;
        game_over  = 1'b0;
        lock_valid = 1'b0;
        lock_lines = 3'd0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        game_start = 1'b0;
        game_over  = 1'b0;
        lock_valid = 1'b0;
        lock_lines = 3'd0;
        m_state    = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (score !== 8'd0 || level !== 4'd0 || lines_total !== 8'd0 || score_tick !== 1'b0 ||
            running !== 1'b0) begin
            failures++;
            $display("FAIL reset got score=%0d level=%0d lines=%0d tick=%0b run=%0b want all 0",
                     score, level, lines_total, score_tick, running);
        end
        rst_n = 1'b1;
        // Locks and game_over in IDLE are ignored.
        drive(1'b0, 1'b0, 1'b1, 3'd4);
        drive(1'b0, 1'b1, 1'b0, 3'd0);
        idle(2);
        checks++;
        if (lines_total !== 8'd0) begin
            failures++;
            $display("FAIL idle_lock got lines=%0d want 0", lines_total);
        end
    endtask

    task automatic test_basic();
        drive(1'b1, 1'b0, 1'b0, 3'd0);
        drive(1'b0, 1'b0, 1'b1, 3'd4);
        idle(3);
    endtask

    task automatic test_level();
        drive(1'b1, 1'b0, 1'b0, 3'd0);
        drive(1'b0, 1'b0, 1'b1, 3'd4);
        drive(1'b0, 1'b0, 1'b1, 3'd4);
        drive(1'b0, 1'b0, 1'b1, 3'd2);
        idle(2);
        checks++;
        if (level !== 4'd1) begin
            failures++;
            $display("FAIL level_step got=%0d want=1", level);
        end
        drive(1'b0, 1'b0, 1'b1, 3'd2);
        idle(2);
        checks++;
        if (score !== 8'd25) begin
            failures++;
            $display("FAIL level_points got=%0d want=25", score);
        end
    endtask

    task automatic test_saturate();
        drive(1'b1, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b1, 3'd4);
            idle(1);
        end
        drive(1'b0, 1'b0, 1'b1, 3'd3);
        idle(2);
        checks++;
        if (score !== 8'd95 || level !== 4'd2) begin
            failures++;
            $display("FAIL pre_sat got score=%0d level=%0d want score=95 level=2", score, level);
        end
        drive(1'b0, 1'b0, 1'b1, 3'd4);
        idle(2);
        drive(1'b0, 1'b0, 1'b1, 3'd1);
        idle(2);
        checks++;
        if (score !== 8'd99) begin
            failures++;
            $display("FAIL saturate got=%0d want=99", score);
        end
    endtask

    task automatic test_start_kill();
        drive(1'b1, 1'b0, 1'b0, 3'd0);
        drive(1'b0, 1'b0, 1'b1, 3'd4);
        drive(1'b1, 1'b0, 1'b1, 3'd4);
        checks++;
        if (score !== 8'd0 || level !== 4'd0 || lines_total !== 8'd0 || score_tick !== 1'b0) begin
            failures++;
            $display("FAIL start_kill got score=%0d level=%0d lines=%0d tick=%0b want all 0",
                     score, level, lines_total, score_tick);
        end
        idle(3);
        checks++;
        if (lines_total !== 8'd0) begin
            failures++;
            $display("FAIL start_drop got lines=%0d want 0", lines_total);
        end
    endtask

    task automatic test_game_over();
        drive(1'b1, 1'b0, 1'b0, 3'd0);
        drive(1'b0, 1'b0, 1'b1, 3'd4);
        drive(1'b0, 1'b1, 1'b1, 3'd4);
        drive(1'b0, 1'b0, 1'b1, 3'd4);
        idle(3);
        checks++;
        if (score !== 8'd8 || lines_total !== 8'd4) begin
            failures++;
            $display("FAIL over_freeze got score=%0d lines=%0d want score=8 lines=4",
                     score, lines_total);
        end
        // game_start from OVER restarts.
        drive(1'b1, 1'b0, 1'b0, 3'd0);
        drive(1'b0, 1'b0, 1'b1, 3'd1);
        idle(2);
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 1'b0, 3'd0);
        drive(1'b0, 1'b0, 1'b1, 3'd4);
        drive(1'b0, 1'b0, 1'b1, 3'd4);
        drive(1'b0, 1'b0, 1'b1, 3'd7);
        drive(1'b0, 1'b0, 1'b1, 3'd2);
        drive(1'b0, 1'b0, 1'b1, 3'd0);
        drive(1'b0, 1'b0, 1'b1, 3'd1);
        idle(3);
        for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b1, 3'($urandom_range(0, 7)));
        idle(3);
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            failures++;
            $display("FAIL drain got pending=%0d want 0", q1.size() + q2.size());
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 1'b0, 3'd0);
        drive(1'b0, 1'b0, 1'b1, 3'd4);
        drive(1'b0, 1'b0, 1'b1, 3'd3);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (score !== 8'd0 || level !== 4'd0 || lines_total !== 8'd0 || score_tick !== 1'b0 ||
            running !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got score=%0d level=%0d lines=%0d tick=%0b run=%0b want 0",
                     score, level, lines_total, score_tick, running);
        end
        m_state = 0;
        model_clear();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        cycle++;
        idle(3);
    endtask

`ifdef SCORE_COMBO_EN
    task automatic test_combo();
        drive(1'b1, 1'b0, 1'b0, 3'd0);
        drive(1'b0, 1'b0, 1'b1, 3'd1);
        drive(1'b0, 1'b0, 1'b1, 3'd1);
        drive(1'b0, 1'b0, 1'b1, 3'd1);
        drive(1'b0, 1'b0, 1'b1, 3'd0);
        drive(1'b0, 1'b0, 1'b1, 3'd1);
        idle(3);
        checks++;
        if (score !== 8'd7) begin
            failures++;
            $display("FAIL combo got=%0d want=7", score);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_level();
        test_saturate();
        test_start_kill();
        test_game_over();
        test_back_to_back();
        test_reset_mid();
`ifdef SCORE_COMBO_EN
        test_combo();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
